axi_stream_fcs_sink: RTL and testbench

- Byte-wide AXI-Stream slave that terminates Ethernet-style frames from the packet generator or the FCS inserter under test.
- Applies pseudo-random backpressure and runs a CRC-32 over every byte, FCS included, using the residue check.
- Checks frame length bounds and reports a per-frame result pulse plus running good/error counters to the testbench scoreboard.
- Synthesizable; also usable as an on-chip loopback checker.

---
 rtl/eth_fcs_pkg.sv | 27 ++
 rtl/bp_lfsr.sv | 37 +++
 rtl/axi_stream_fcs_sink.sv | 155 +++++++++++++++
 tb/tb_axi_stream_fcs_sink.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_fcs_pkg.sv
// Shared Ethernet FCS definitions: reflected CRC-32 constants, the
// byte-serial CRC step, and the state encoding of the frame sink.
// Used by the FCS sink and by the FCS inserter / generator model.
package eth_fcs_pkg;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  // Register value left behind after folding a correct FCS into the CRC.
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } sink_state_e;

  // One byte of reflected CRC-32, LSB of the byte first.
  function automatic logic [31:0] crc32_next_byte(logic [31:0] crc, logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/bp_lfsr.sv
// Pseudo-random ready generator: 16-bit Fibonacci LFSR (taps 16,14,13,11)
// plus a threshold compare on its low byte.
// Ports:
//   clk, rst        clock, synchronous active-high reset (loads SEED)
//   bp_en_i         1 = random pattern, 0 = ready_next_o held 1
//   ready_next_o    value to register as the next ready / valid
module bp_lfsr #(
  parameter int          THRESH = 192,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic bp_en_i,
  output logic ready_next_o
);

  // 9 bits so that THRESH = 256 means "always below threshold".
  localparam logic [8:0] THRESH_W = 9'(THRESH);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;

  assign fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr_d = {lfsr_q[14:0], fb};

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign ready_next_o = !bp_en_i || ({1'b0, lfsr_q[7:0]} < THRESH_W);

endmodule

// File: rtl/axi_stream_fcs_sink.sv
// Byte-wide AXI-Stream frame sink. Applies pseudo-random backpressure,
// runs CRC-32 over every byte (FCS included) and checks the residue,
// checks length bounds, and reports a per-frame result pulse plus
// running good/error counters.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_axis_*          byte stream in (tdata/tvalid/tlast in, tready out)
//   bp_en             1 = random backpressure, 0 = tready held 1
//   frame_done        one-cycle pulse, result fields valid
//   frame_len         byte count of last frame (saturating 16'hFFFF)
//   crc_ok, len_err   result flags of last frame (held until next frame_done)
//   frames_rcvd, crc_errs, len_errs   wrapping 32-bit counters
//
// Handshake: a beat transfers on a rising edge where tvalid && tready.
// tready is built only from registers (LFSR-driven flop gated by the
// DONE state), never from tvalid, and may drop while tvalid is high.
module axi_stream_fcs_sink
  import eth_fcs_pkg::*;
#(
  parameter int          MIN_BYTES    = 64,
  parameter int          MAX_BYTES    = 1518,
  parameter int          READY_THRESH = 192,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        bp_en,
  output logic        frame_done,
  output logic [15:0] frame_len,
  output logic        crc_ok,
  output logic        len_err,
  output logic [31:0] frames_rcvd,
  output logic [31:0] crc_errs,
  output logic [31:0] len_errs
);

  localparam logic [31:0] MIN_W = 32'(MIN_BYTES);
  localparam logic [31:0] MAX_W = 32'(MAX_BYTES);

  sink_state_e state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        tready_q;
  logic        ready_next;
  logic [15:0] frame_len_q, frame_len_d;
  logic        crc_ok_q, crc_ok_d;
  logic        len_err_q, len_err_d;
  logic [31:0] frames_q, frames_d;
  logic [31:0] crc_errs_q, crc_errs_d;
  logic [31:0] len_errs_q, len_errs_d;

  logic        beat;
  logic [31:0] crc_upd;
  logic [15:0] cnt_inc;
  logic        len_bad;

  bp_lfsr #(
    .THRESH (READY_THRESH),
    .SEED   (SEED)
  ) u_bp_lfsr (
    .clk          (clk),
    .rst          (rst),
    .bp_en_i      (bp_en),
    .ready_next_o (ready_next)
  );

  // DONE blocks the stream for its single cycle.
  assign s_axis_tready = tready_q && (state_q != ST_DONE);
  assign beat          = s_axis_tvalid && s_axis_tready;

  assign crc_upd = crc32_next_byte(crc_q, s_axis_tdata);
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  // A saturated count means the real length is unknown, so it is always bad.
  assign len_bad = (cnt_inc == 16'hFFFF) ||
                   ({16'h0000, cnt_inc} < MIN_W) ||
                   ({16'h0000, cnt_inc} > MAX_W);

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    frame_len_d = frame_len_q;
    crc_ok_d    = crc_ok_q;
    len_err_d   = len_err_q;
    frames_d    = frames_q;
    crc_errs_d  = crc_errs_q;
    len_errs_d  = len_errs_q;
    case (state_q)
      ST_IDLE, ST_RECV: begin
        if (beat) begin
          crc_d = crc_upd;
          cnt_d = cnt_inc;
          if (s_axis_tlast) begin
            // Results are latched on the tlast beat so they are already
            // stable while frame_done is high.
            state_d     = ST_DONE;
            frame_len_d = cnt_inc;
            crc_ok_d    = (crc_upd == CRC_RESIDUE);
            len_err_d   = len_bad;
          end else begin
            state_d = ST_RECV;
          end
        end
      end
      ST_DONE: begin
        frames_d = frames_q + 32'd1;
        if (!crc_ok_q) crc_errs_d = crc_errs_q + 32'd1;
        if (len_err_q) len_errs_d = len_errs_q + 32'd1;
        crc_d   = CRC_INIT;
        cnt_d   = 16'd0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      crc_q       <= CRC_INIT;
      cnt_q       <= 16'd0;
      tready_q    <= 1'b0;
      frame_len_q <= 16'd0;
      crc_ok_q    <= 1'b0;
      len_err_q   <= 1'b0;
      frames_q    <= 32'd0;
      crc_errs_q  <= 32'd0;
      len_errs_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      tready_q    <= ready_next;
      frame_len_q <= frame_len_d;
      crc_ok_q    <= crc_ok_d;
      len_err_q   <= len_err_d;
      frames_q    <= frames_d;
      crc_errs_q  <= crc_errs_d;
      len_errs_q  <= len_errs_d;
    end
  end

  assign frame_done  = (state_q == ST_DONE);
  assign frame_len   = frame_len_q;
  assign crc_ok      = crc_ok_q;
  assign len_err     = len_err_q;
  assign frames_rcvd = frames_q;
  assign crc_errs    = crc_errs_q;
  assign len_errs    = len_errs_q;

endmodule

// File: tb/tb_axi_stream_fcs_sink.sv
`timescale 1ns/1ps
// Bench for axi_stream_fcs_sink. Two instances share one driver:
// dut A (MIN_BYTES=8, READY_THRESH=64) and dut B (defaults); sel picks
// which one sees tvalid and whose outputs are observed.
module tb_axi_stream_fcs_sink;

  localparam int MAXB  = 1518;
  localparam int MIN_A = 8;
  localparam int MIN_B = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] tdata  = 8'h00;
  logic       tvalid = 1'b0;
  logic       tlast  = 1'b0;
  logic       bp_en  = 1'b0;
  logic       sel    = 1'b0;

  logic [1:0]  tvalid_v, tready_v, done_v, crc_ok_v, len_err_v;
  logic [15:0] len_w    [2];
  logic [31:0] frames_w [2];
  logic [31:0] crcerr_w [2];
  logic [31:0] lenerr_w [2];

  assign tvalid_v[0] = tvalid && !sel;
  assign tvalid_v[1] = tvalid && sel;

  logic        tready, frame_done, crc_ok, len_err;
  logic [15:0] frame_len;
  logic [31:0] frames_rcvd, crc_errs, len_errs;
  assign tready      = tready_v[sel];
  assign frame_done  = done_v[sel];
  assign crc_ok      = crc_ok_v[sel];
  assign len_err     = len_err_v[sel];
  assign frame_len   = sel ? len_w[1]    : len_w[0];
  assign frames_rcvd = sel ? frames_w[1] : frames_w[0];
  assign crc_errs    = sel ? crcerr_w[1] : crcerr_w[0];
  assign len_errs    = sel ? lenerr_w[1] : lenerr_w[0];

  axi_stream_fcs_sink #(
    .MIN_BYTES(MIN_A), .MAX_BYTES(MAXB), .READY_THRESH(64), .SEED(16'hACE1)
  ) u_dut_a (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid_v[0]),
    .s_axis_tready(tready_v[0]), .s_axis_tlast(tlast), .bp_en(bp_en),
    .frame_done(done_v[0]), .frame_len(len_w[0]), .crc_ok(crc_ok_v[0]),
    .len_err(len_err_v[0]), .frames_rcvd(frames_w[0]), .crc_errs(crcerr_w[0]),
    .len_errs(lenerr_w[0])
  );

  axi_stream_fcs_sink u_dut_b (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid_v[1]),
    .s_axis_tready(tready_v[1]), .s_axis_tlast(tlast), .bp_en(bp_en),
    .frame_done(done_v[1]), .frame_len(len_w[1]), .crc_ok(crc_ok_v[1]),
    .len_err(len_err_v[1]), .frames_rcvd(frames_w[1]), .crc_errs(crcerr_w[1]),
    .len_errs(lenerr_w[1])
  );

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [17:0] exp_q[$];          // {frame_len, crc_ok, len_err}
  int          m_frames[2];
  int          m_crcerr[2];
  int          m_lenerr[2];
  logic [15:0] m_last_len[2];
  bit          pend_last = 1'b0;
  logic [31:0] crc_tab[256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] fcs_of(input logic [7:0] b[$], input int n);
    logic [31:0] c;
    logic [7:0]  idx;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      idx = c[7:0] ^ b[i];
      c = crc_tab[idx] ^ (c >> 8);
    end
    return ~c;
  endfunction

  // Good frame <=> FCS of the payload equals the trailing 4 bytes (LE).
  function automatic logic [17:0] model_result(input logic [7:0] b[$], input int min_len);
    int          n;
    logic [31:0] rx;
    logic        ok, lerr;
    logic [15:0] len;
    n    = b.size();
    rx   = {b[n-1], b[n-2], b[n-3], b[n-4]};
    ok   = (fcs_of(b, n - 4) == rx);
    len  = (n >= 65535) ? 16'hFFFF : 16'(n);
    lerr = (n < min_len) || (n > MAXB) || (n >= 65535);
    return {len, ok, lerr};
  endfunction

  task automatic make_good(input int n, output logic [7:0] b[$]);
    logic [31:0] f;
    b = {};
    for (int i = 0; i < n - 4; i++) b.push_back(8'($urandom_range(0, 255)));
    f = fcs_of(b, n - 4);
    b.push_back(f[7:0]);
    b.push_back(f[15:8]);
    b.push_back(f[23:16]);
    b.push_back(f[31:24]);
  endtask

  // ---------------- driver tasks (enter/leave at posedge+1) ----------------
  task automatic send_frame(input logic [7:0] b[$], input bit with_last, input bit gaps);
    int wait_n;
    for (int i = 0; i < b.size(); i++) begin
      if (gaps && $urandom_range(0, 9) == 0) begin
        tvalid = 1'b0;
        tlast  = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      tdata  = b[i];
      tvalid = 1'b1;
      tlast  = with_last && (i == b.size() - 1);
      wait_n = 0;
      @(negedge clk);
      while (!tready && wait_n < 2000) begin
        wait_n++;
        @(negedge clk);
      end
      if (!tready) begin
        check("beat_timeout", {31'd0, tready}, 32'd1);
        tvalid = 1'b0;
        tlast  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int d = 0; d < 2; d++) begin
      m_frames[d] = 0; m_crcerr[d] = 0; m_lenerr[d] = 0; m_last_len[d] = 16'd0;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_counts(input string tag);
    int d;
    repeat (3) @(posedge clk);
    @(negedge clk);
    d = int'(sel);
    check({tag, ".missing_done"}, 32'(exp_q.size()), 32'd0);
    check({tag, ".frames_rcvd"}, frames_rcvd, 32'(m_frames[d]));
    check({tag, ".crc_errs"}, crc_errs, 32'(m_crcerr[d]));
    check({tag, ".len_errs"}, len_errs, 32'(m_lenerr[d]));
    check({tag, ".frame_len_hold"}, {16'd0, frame_len}, {16'd0, m_last_len[d]});
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [17:0] e;
    if (rst) begin
      pend_last = 1'b0;
    end else begin
      if (pend_last) begin
        check("done_latency", {31'd0, frame_done}, 32'd1);
        pend_last = 1'b0;
      end else if (frame_done) begin
        check("spurious_done", {31'd0, frame_done}, 32'd0);
      end
      if (frame_done) begin
        check("done_tready", {31'd0, tready}, 32'd0);
        if (exp_q.size() == 0) begin
          check("no_expected_frame", {31'd0, frame_done}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("frame_len", {16'd0, frame_len}, {16'd0, e[17:2]});
          check("crc_ok", {31'd0, crc_ok}, {31'd0, e[1]});
          check("len_err", {31'd0, len_err}, {31'd0, e[0]});
          m_frames[sel]++;
          if (!e[1]) m_crcerr[sel]++;
          if (e[0])  m_lenerr[sel]++;
          m_last_len[sel] = e[17:2];
        end
      end
      if (tvalid && tready && tlast) pend_last = 1'b1;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic        dut;
    bit          rst_before;
    int          kind;        // 0 check string, 1 corrupted string, 2 good random, 3 zero bytes
    int          len;
    logic [15:0] e_len;
    logic        e_crc;
    logic        e_lerr;
  } vec_t;

  vec_t        tbl[10];
  logic [7:0]  chk_str[13];
  logic [7:0]  fr[$];
  logic [17:0] r;

  initial begin
    logic [31:0] c;
    for (int k = 0; k < 256; k++) begin
      c = 32'(k);
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[k] = c;
    end
    chk_str = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                8'h26, 8'h39, 8'hF4, 8'hCB};
    tbl[0] = '{1'b0, 1'b0, 0, 13,   16'd13,   1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1, 13,   16'd13,   1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 2, 8,    16'd8,    1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 2, 7,    16'd7,    1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 3, 1,    16'd1,    1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 2, 63,   16'd63,   1'b1, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 2, 64,   16'd64,   1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 2, 1518, 16'd1518, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 2, 1519, 16'd1519, 1'b1, 1'b1};
    tbl[9] = '{1'b1, 1'b0, 3, 1,    16'd1,    1'b0, 1'b1};

    // reset state of both instances
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #1;
      check("rst.tready", {31'd0, tready}, 32'd0);
      check("rst.frame_done", {31'd0, frame_done}, 32'd0);
      check("rst.frame_len", {16'd0, frame_len}, 32'd0);
      check("rst.crc_ok", {31'd0, crc_ok}, 32'd0);
      check("rst.len_err", {31'd0, len_err}, 32'd0);
      check("rst.frames_rcvd", frames_rcvd, 32'd0);
      check("rst.crc_errs", crc_errs, 32'd0);
      check("rst.len_errs", len_errs, 32'd0);
    end
    sel = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // table-driven vectors, bp_en = 0
    for (int v = 0; v < 10; v++) begin
      sel = tbl[v].dut;
      if (tbl[v].rst_before) apply_reset();
      fr = {};
      case (tbl[v].kind)
        0: for (int i = 0; i < 13; i++) fr.push_back(chk_str[i]);
        1: begin
          for (int i = 0; i < 13; i++) fr.push_back(chk_str[i]);
          fr[4] = 8'h34;
        end
        2: make_good(tbl[v].len, fr);
        default: for (int i = 0; i < tbl[v].len; i++) fr.push_back(8'h00);
      endcase
      exp_q.push_back({tbl[v].e_len, tbl[v].e_crc, tbl[v].e_lerr});
      send_frame(fr, 1'b1, 1'b0);
      check_counts($sformatf("vec%0d", v));
    end

    // random back-to-back frames with backpressure on dut A
    sel = 1'b0;
    apply_reset();
    bp_en = 1'b1;
    for (int f = 0; f < 100; f++) begin
      make_good($urandom_range(5, 100), fr);
      if ($urandom_range(0, 7) == 0) begin
        int k;
        k = $urandom_range(0, fr.size() - 1);
        fr[k] = fr[k] ^ (8'h01 << $urandom_range(0, 7));
      end
      r = model_result(fr, MIN_A);
      exp_q.push_back(r);
      send_frame(fr, 1'b1, 1'b1);
    end
    check_counts("bp");
    check("bp.frame_total", frames_rcvd, 32'd100);
    bp_en = 1'b0;

    // reset in the middle of a frame on dut B, then a good 64-byte frame
    sel = 1'b1;
    apply_reset();
    make_good(64, fr);
    fr = fr[0:29];
    send_frame(fr, 1'b0, 1'b0);
    apply_reset();
    make_good(64, fr);
    exp_q.push_back({16'd64, 1'b1, 1'b0});
    send_frame(fr, 1'b1, 1'b0);
    check_counts("midrst");
    check("midrst.frames", frames_rcvd, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
